// File: rtl/mux_pkg.sv
// Shared defaults, mode encodings and output-register state type for mux_rr_reg.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int N_DEF     = 4;

  localparam logic MODE_SEL = 1'b0;  // explicit select via sel
  localparam logic MODE_RR  = 1'b1;  // round-robin arbitration

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set req bit searching from ptr+1 upward, modulo N.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides whether the grant is used.
// Ports: req[N] requests, ptr last-granted index; gnt_valid any request, gnt_idx chosen index.
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  logic [SELW-1:0] idx;

  // Walk the search order backwards so the last hit written is the
  // highest-priority one (offset 1 from ptr).
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = SELW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// N-to-1 mux with explicit-select or round-robin arbitration into a single output register.
// Latency: 1 cycle from the transfer edge to o_valid; full throughput of one word per cycle.
// Backpressure: in_ready drops to zero while the register is FULL and o_ready=0.
// Ports: clk/rst_n; mode, sel choose the grant; in_data/in_valid/in_ready per channel;
//        o, o_valid, o_ch output word, its valid and source channel; o_ready downstream accept.
module mux_rr_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF,
  localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   o,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [SELW-1:0]    o_ch
);

  out_state_e      state_q, state_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [SELW-1:0] o_ch_q, o_ch_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            rr_vld;
  logic [SELW-1:0] rr_idx;
  logic [N-1:0]    sel_shift;
  logic            sel_hit;
  logic            gnt_vld;
  logic [SELW-1:0] gnt_idx;
  logic            can_accept;
  logic            xfer;
  logic [N*WIDTH-1:0] data_shift;
  logic [WIDTH-1:0]   gnt_dat;

  rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_vld),
    .gnt_idx   (rr_idx)
  );

  // Shifting instead of indexing keeps an out-of-range sel (sel>=N) safe:
  // it shifts in zeros and therefore never grants.
  assign sel_shift = in_valid >> sel;
  assign sel_hit   = sel_shift[0] && (int'(sel) < N);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (mode == MODE_RR) begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end else begin
      gnt_vld = sel_hit;
      gnt_idx = sel;
    end
  end

  assign can_accept = (state_q == ST_EMPTY) || o_ready;
  // rst_n gating: state_q already reads EMPTY during reset, which alone
  // would let a grant through.
  assign xfer       = gnt_vld && can_accept && rst_n;
  assign in_ready   = xfer ? (N'(1) << gnt_idx) : '0;

  assign data_shift = in_data >> (int'(gnt_idx) * WIDTH);
  assign gnt_dat    = data_shift[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    o_ch_d  = o_ch_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = ST_FULL;
      o_d     = gnt_dat;
      o_ch_d  = gnt_idx;
      ptr_d   = gnt_idx;
    end else if ((state_q == ST_FULL) && o_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      o_q     <= '0;
      o_ch_q  <= '0;
      ptr_q   <= SELW'(N - 1);
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      o_ch_q  <= o_ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o       = o_q;
  assign o_ch    = o_ch_q;
  assign o_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: vector table, hand-written corner sequences, randomized run vs model.
// Latency: checks one-cycle load latency.
// Backpressure: checks stall holding and in_ready gating.
module tb_mux_rr_reg;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] o;
  logic        o_valid;
  logic        o_ready;
  logic [1:0]  o_ch;

  // Second build with N=5 so sel can point past the last channel.
  logic        mode5;
  logic [2:0]  sel5;
  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [7:0]  o5;
  logic        o_valid5;
  logic        o_ready5;
  logic [2:0]  o_ch5;

  int total = 0;
  int bad   = 0;

  mux_rr_reg #(.WIDTH(16), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .o(o), .o_valid(o_valid),
    .o_ready(o_ready), .o_ch(o_ch)
  );

  mux_rr_reg #(.WIDTH(8), .N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5), .in_data(in_data5),
    .in_valid(in_valid5), .in_ready(in_ready5), .o(o5), .o_valid(o_valid5),
    .o_ready(o_ready5), .o_ch(o_ch5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: output register as a 0/1-entry slot plus last-winner index.
  bit          m_full;
  logic [15:0] m_o;
  int          m_ch;
  int          m_ptr;

  function automatic void mgrant(input logic md, input logic [1:0] s, input logic [3:0] v,
                                 input int p, output bit gv, output int gi);
    gv = 0;
    gi = 0;
    if (md == 1'b0) begin
      if (v[s]) begin
        gv = 1;
        gi = int'(s);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (!gv && v[(p + k) % 4]) begin
          gv = 1;
          gi = (p + k) % 4;
        end
      end
    end
  endfunction

  task automatic model_reset();
    m_full = 0;
    m_o    = '0;
    m_ch   = 0;
    m_ptr  = 3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        md;
    logic [1:0]  s;
    logic [3:0]  v;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [1:0]  exp_ch;
    logic [15:0] exp_o;
  } vec_t;

  vec_t vec[11];

  bit   gv;
  int   gi;
  logic [3:0]  exp_rdy;
  logic [15:0] hold_o;
  logic [1:0]  hold_ch;

  initial begin
    // Channel data: ch0=00F0, ch1=0001, ch2=0002, ch3=0003.
    vec[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h00F0};
    vec[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0001};
    vec[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h0002};
    vec[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h0003};
    vec[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h00F0};
    vec[5]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h0003};
    vec[6]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h00F0};
    vec[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h0003};
    vec[8]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 16'h0003};
    vec[9]  = '{1'b0, 2'd2, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 16'h0002};
    vec[10] = '{1'b0, 2'd2, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h0002};

    rst_n = 1'b0;
    mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; o_ready = 1'b1;
    in_data = {16'h0003, 16'h0002, 16'h0001, 16'h00F0};
    mode5 = 1'b0; sel5 = 3'd5; in_valid5 = 5'b11111; o_ready5 = 1'b1;
    in_data5 = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    model_reset();

    // Reset state, with requests present.
    repeat (2) @(negedge clk);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_o_ch", 32'(o_ch), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table: round-robin order from reset, 1001 alternation, drain, stall.
    for (int i = 0; i < 11; i++) begin
      mode = vec[i].md; sel = vec[i].s; in_valid = vec[i].v; o_ready = vec[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vec[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_o_valid", i), 32'(o_valid), 32'(vec[i].exp_vld));
      chk($sformatf("vec%0d_o_ch", i), 32'(o_ch), 32'(vec[i].exp_ch));
      chk($sformatf("vec%0d_o", i), 32'(o), 32'(vec[i].exp_o));
    end

    // Explicit select right after reset release.
    do_reset();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; o_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("sel1_o", 32'(o), 32'h0001);
    chk("sel1_o_ch", 32'(o_ch), 32'd1);
    chk("sel1_o_valid", 32'(o_valid), 32'd1);

    // Stall for 3 cycles, then release: next word loads on the following edge.
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; o_ready = 1'b0;
    hold_o = o; hold_ch = o_ch;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("stall%0d_o", c), 32'(o), 32'(hold_o));
      chk($sformatf("stall%0d_o_ch", c), 32'(o_ch), 32'(hold_ch));
      chk($sformatf("stall%0d_o_valid", c), 32'(o_valid), 32'd1);
    end
    @(posedge clk);
    #1 o_ready = 1'b1;
    @(negedge clk);
    chk("unstall_in_ready", 32'(in_ready), 32'b1000);
    @(posedge clk);
    #1;
    chk("unstall_o", 32'(o), 32'h0003);
    chk("unstall_o_ch", 32'(o_ch), 32'd3);

    // Out-of-range select on the N=5 build never grants.
    for (int s = 5; s <= 7; s++) begin
      sel5 = 3'(s);
      @(negedge clk);
      chk($sformatf("oor_sel%0d_in_ready", s), 32'(in_ready5), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("oor_sel%0d_o_valid", s), 32'(o_valid5), 32'd0);
    end
    sel5 = 3'd4;
    @(negedge clk);
    chk("sel4_in_ready", 32'(in_ready5), 32'b10000);
    @(posedge clk);
    #1;
    chk("sel4_o", 32'(o5), 32'h44);

    // Reset while FULL: immediate clear, then round-robin restarts at channel 0.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; o_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("prersv_o_valid", 32'(o_valid), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    chk("midrst_o", 32'(o), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 1'b1; in_valid = 4'b1010; o_ready = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 32'(in_ready), 32'b0010);
    @(posedge clk);
    #1;
    chk("postrst_o_ch", 32'(o_ch), 32'd1);
    chk("postrst_o_valid", 32'(o_valid), 32'd1);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      mode     = 1'($urandom_range(0, 1));
      sel      = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom_range(0, 15));
      o_ready  = ($urandom_range(0, 3) != 0);
      in_data  = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      @(negedge clk);
      mgrant(mode, sel, in_valid, m_ptr, gv, gi);
      exp_rdy = (gv && (!m_full || o_ready)) ? (4'b0001 << gi) : 4'b0000;
      chk($sformatf("rnd%0d_in_ready", c), 32'(in_ready), 32'(exp_rdy));
      chk($sformatf("rnd%0d_o_valid", c), 32'(o_valid), 32'(m_full));
      chk($sformatf("rnd%0d_o_ch", c), 32'(o_ch), 32'(m_ch));
      chk($sformatf("rnd%0d_o", c), 32'(o), 32'(m_o));
      @(posedge clk);
      if (exp_rdy != 4'b0000) begin
        m_full = 1;
        m_o    = in_data[gi*16 +: 16];
        m_ch   = gi;
        m_ptr  = gi;
      end else if (m_full && o_ready) begin
        m_full = 0;
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
